// File: rtl/updown_seq_checker_if.sv
// updown_seq_checker_if: sample/report bundle between a counter stream source and the checker
interface updown_seq_checker_if #(parameter int ERR_W = 8);
  logic             en;
  logic [2:0]       cnt_in;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic             period_done;
  logic [2:0]       exp_cnt;
  logic [ERR_W-1:0] err_count;
  modport master(output en, cnt_in, clr_err, input locked, err, period_done, exp_cnt, err_count);
  modport slave(input en, cnt_in, clr_err, output locked, err, period_done, exp_cnt, err_count);
endinterface

// File: rtl/updown_seq_checker.sv
// updown_seq_checker: locks to the 15-step up/down counter period, flywheels the expected value and counts mismatches
module updown_seq_checker #(
  parameter int ERR_W = 8,
  parameter int LOSS_THRESH = 3
) (
  input logic clk,
  input logic rst,
  updown_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {HUNT, LOCKED, SLIP} state_t;
  state_t state, state_n;
  logic [3:0] phase, phase_n, phase_inc;
  logic [2:0] miss, miss_n, exp_v;
  logic err_q, err_n, pd_q, pd_n, hit, mis;
  logic [ERR_W-1:0] cnt_q, cnt_n;
  function automatic logic [2:0] golden(input logic [3:0] p);
    case (p)
      4'd0, 4'd15, 4'd13: golden = 3'd1;
      4'd1, 4'd12:        golden = 3'd2;
      4'd2, 4'd11:        golden = 3'd3;
      4'd3, 4'd9, 4'd10:  golden = 3'd4;
      4'd4, 4'd8:         golden = 3'd5;
      4'd5, 4'd7:         golden = 3'd6;
      4'd6:               golden = 3'd7;
      default:            golden = 3'd0;
    endcase
  endfunction
  assign exp_v     = (state == HUNT) ? 3'd0 : golden(phase);
  assign hit       = bus.cnt_in == exp_v;
  assign mis       = bus.en && state != HUNT && !hit;
  assign phase_inc = (phase >= 4'd14) ? 4'd0 : phase + 4'd1;
  always_comb begin
    state_n = state;
    phase_n = phase;
    miss_n  = miss;
    err_n   = 1'b0;
    pd_n    = 1'b0;
    if (bus.en) begin
      if (state == HUNT) begin
        if (bus.cnt_in == 3'd0) begin
          state_n = LOCKED;
          phase_n = 4'd0;
          miss_n  = 3'd0;
        end
      end else if (hit) begin
        state_n = LOCKED;
        phase_n = phase_inc;
        miss_n  = 3'd0;
        pd_n    = bus.cnt_in == 3'd0;
      end else begin
        err_n   = 1'b1;
        miss_n  = miss + 3'd1;
        phase_n = phase_inc;
        state_n = SLIP;
        // LOCKED has miss==0, so LOSS_THRESH==1 drops straight to HUNT here too
        if (miss_n == 3'(LOSS_THRESH)) begin
          state_n = HUNT;
          phase_n = 4'd0;
          miss_n  = 3'd0;
        end
      end
    end
    cnt_n = bus.clr_err ? ERR_W'(mis) : (mis && !(&cnt_q)) ? cnt_q + ERR_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      phase <= 4'd0;
      miss  <= 3'd0;
      err_q <= 1'b0;
      pd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      miss  <= miss_n;
      err_q <= err_n;
      pd_q  <= pd_n;
      cnt_q <= cnt_n;
    end
  end
  assign bus.locked      = state != HUNT;
  assign bus.err         = err_q;
  assign bus.period_done = pd_q;
  assign bus.exp_cnt     = exp_v;
  assign bus.err_count   = cnt_q;
endmodule

// File: tb/tb_updown_seq_checker.sv
// tb_updown_seq_checker: directed streams against a period/lock model, two instances (8-bit and 2-bit error counters)
module tb_updown_seq_checker;
  localparam int LOSS = 3;
  logic clk = 0, rst = 1, en = 0, clr = 0, go = 0;
  logic [2:0] cin = 0;
  always #5 clk = ~clk;
  updown_seq_checker_if #(.ERR_W(8)) a();
  updown_seq_checker_if #(.ERR_W(2)) b();
  assign a.en = en;
  assign a.cnt_in = cin;
  assign a.clr_err = clr;
  assign b.en = en;
  assign b.cnt_in = cin;
  assign b.clr_err = clr;
  updown_seq_checker #(.ERR_W(8), .LOSS_THRESH(LOSS)) dut_a(.clk(clk), .rst(rst), .bus(a.slave));
  updown_seq_checker #(.ERR_W(2), .LOSS_THRESH(LOSS)) dut_b(.clk(clk), .rst(rst), .bus(b.slave));
  int G[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 4, 3, 2, 1, 0};
  int n_cmp = 0, n_fail = 0;
  bit m_lock, m_err, m_pd;
  int m_phase, m_miss, c8, c2;
  int ph, pd_seen;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    bit mis;
    if (rst) begin
      m_lock = 0; m_err = 0; m_pd = 0; m_phase = 0; m_miss = 0; c8 = 0; c2 = 0;
    end else begin
      mis = 0; m_err = 0; m_pd = 0;
      if (en) begin
        if (!m_lock) begin
          if (cin == 0) begin m_lock = 1; m_phase = 0; m_miss = 0; end
        end else if (int'(cin) == G[m_phase]) begin
          m_pd = cin == 0; m_miss = 0; m_phase = (m_phase + 1) % 15;
        end else begin
          mis = 1; m_err = 1; m_miss++;
          if (m_miss >= LOSS) begin m_lock = 0; m_phase = 0; m_miss = 0; end
          else m_phase = (m_phase + 1) % 15;
        end
      end
      if (clr) begin c8 = int'(mis); c2 = int'(mis); end
      else if (mis) begin
        if (c8 < 255) c8++;
        if (c2 < 3) c2++;
      end
    end
  end
  always @(negedge clk) if (go) begin
    chk("locked_a", a.locked, m_lock);
    chk("err_a", a.err, m_err);
    chk("pd_a", a.period_done, m_pd);
    chk("exp_a", a.exp_cnt, m_lock ? G[m_phase] : 0);
    chk("cnt_a", a.err_count, c8);
    chk("locked_b", b.locked, m_lock);
    chk("err_b", b.err, m_err);
    chk("exp_b", b.exp_cnt, m_lock ? G[m_phase] : 0);
    chk("cnt_b", b.err_count, c2);
  end
  task automatic step(input logic e, input logic [2:0] v, input logic c);
    en = e; cin = v; clr = c;
    @(posedge clk);
    #1;
    if (a.period_done) pd_seen++;
  endtask
  task automatic ideal();
    step(1, 3'(G[ph]), 0);
    ph = (ph + 1) % 15;
  endtask
  task automatic bad(input logic c);
    step(1, 3'((G[ph] + 1) % 8), c);
    ph = (ph + 1) % 15;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0; go = 1;
    chk("rst_locked", a.locked, 0);
    chk("rst_exp", a.exp_cnt, 0);
    chk("rst_cnt", a.err_count, 0);
    step(1, 0, 0);
    chk("lock_first", a.locked, 1);
    chk("lock_exp1", a.exp_cnt, 1);
    ph = 0; pd_seen = 0;
    repeat (39) ideal();
    chk("ideal_pd_count", pd_seen, 2);
    chk("ideal_cnt", a.err_count, 0);
    ideal();
    bad(0);
    chk("slip_err", a.err, 1);
    chk("slip_locked", a.locked, 1);
    chk("slip_cnt", a.err_count, 1);
    ideal();
    chk("relock_err", a.err, 0);
    chk("relock_locked", a.locked, 1);
    repeat (2) ideal();
    step(0, 0, 1);
    chk("clr_idle", a.err_count, 0);
    repeat (3) bad(0);
    chk("loss_locked", a.locked, 0);
    chk("loss_cnt_a", a.err_count, 3);
    chk("loss_cnt_b", b.err_count, 3);
    while (G[ph] != 0) begin
      ideal();
      chk("hunt_err", a.err, 0);
    end
    ideal();
    chk("hunt_relock", a.locked, 1);
    ideal();
    chk("hunt_match", a.err, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    ph = 4;
    while (G[ph] != 0) begin
      ideal();
      chk("mid_unlocked", a.locked, 0);
    end
    ideal();
    chk("mid_locked", a.locked, 1);
    chk("mid_exp", a.exp_cnt, 1);
    ideal();
    chk("mid_match", a.err, 0);
    repeat (10) begin
      ideal();
      step(0, 0, 0);
      chk("hold_exp", a.exp_cnt, G[ph]);
    end
    step(0, 0, 1);
    repeat (5) begin bad(0); ideal(); end
    chk("sat_b", b.err_count, 3);
    chk("sat_a", a.err_count, 5);
    bad(1);
    chk("clr_mis_a", a.err_count, 1);
    chk("clr_mis_b", b.err_count, 1);
    chk("clr_mis_err", a.err, 1);
    #3 rst = 1;
    #1;
    chk("arst_locked", a.locked, 0);
    chk("arst_err", a.err, 0);
    chk("arst_pd", a.period_done, 0);
    chk("arst_exp", a.exp_cnt, 0);
    chk("arst_cnt_a", a.err_count, 0);
    chk("arst_cnt_b", b.err_count, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/updown_seq_checker.md
Name: updown_seq_checker

Overview:
- Receiver-side monitor for the 3-bit up/down pattern counter.
- Samples the counter value each enabled cycle and locks to the counter's fixed 15-value period.
- Flywheels a local expected value and flags deviations; loses lock after repeated consecutive errors.
- Sits beside the counter in the system and in benches as a self-checking sink; reports lock, error pulses and a saturating error count.

Parameters:
- ERR_W, 8: width of error counter (saturates at 2^ERR_W-1).
- LOSS_THRESH, 3: consecutive mismatches that drop lock (legal 1..7).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; cnt_in is checked only on cycles with en=1.
- cnt_in  input  3  counter value under test.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  high in LOCKED or SLIP states.
- err  output  1  one-cycle pulse, cycle after a mismatching sample.
- period_done  output  1  one-cycle pulse, cycle after a matching 0 sample while locked.
- exp_cnt  output  3  value expected at the next sample (0 in HUNT).
- err_count  output  ERR_W  saturating mismatch count.

Behaviour:
- Golden period, phase index 0..14: 1,2,3,4,5,6,7,6,5,4,4,3,2,1,0; then wraps to phase 0 (value 1).
- Phase register is 4 bits. 14 wraps to 0; values 15 are unreachable and treated as 0.
- Expected values come from a constant lookup on phase; no stored memory.
- Reset (async, any time, including mid-period): state=HUNT, phase=0, miss=0.
  - Outputs at reset: locked=0, err=0, period_done=0, exp_cnt=0, err_count=0.
- FSM states: HUNT, LOCKED, SLIP. Nothing changes on cycles with en=0; pulses deassert.
- HUNT:
  - en && cnt_in==0: go to LOCKED, phase=0, so exp_cnt=1 next cycle.
  - Other samples are ignored: no err, no count.
  - 0 is unique in the period, so lock is unambiguous. The 4,4 repeat never lands on a sync point.
- LOCKED, on en:
  - cnt_in==exp_cnt: advance phase. If the matched value is 0, pulse period_done.
  - Mismatch: pulse err, increment err_count, miss=1, advance phase (flywheel), go to SLIP.
  - If LOSS_THRESH==1, a mismatch goes directly to HUNT instead of SLIP.
- SLIP, on en:
  - Match: miss=0, go to LOCKED, advance phase.
  - Mismatch: pulse err, increment err_count, miss+1, advance phase.
  - If miss+1==LOSS_THRESH: go to HUNT, phase=0, miss=0.
- exp_cnt is registered and equals the table value at the current phase when locked, 0 in HUNT.
- err_count saturates at all-ones; further mismatches still pulse err.
- clr_err zeroes err_count.
  - If clr_err coincides with a mismatch, the result is err_count=1 (clear, then count).
- The mismatch sample that causes loss of lock still pulses err and counts.
- The sample that achieves lock in HUNT produces no err.
- Latency: err, period_done and locked update one clk after the sampling edge.

Test Plan:
- Reset, then en=1 every cycle with the ideal stream 0,1,2,3,4,5,6,7,6,5,4,4,3,2,1,0,1… for 40 samples:
  - locked=1 from cycle 2 onward.
  - err never asserts; err_count=0.
  - period_done pulses exactly twice, one cycle after each in-lock 0.
- Locked stream with the second 4 replaced by 5: single err pulse, err_count=1; state goes LOCKED→SLIP→LOCKED on the next matching 3; locked stays 1 throughout.
- Locked, then three consecutive corrupted samples (LOSS_THRESH=3): err pulses 3 times, err_count=3; locked=0 after the third; relocks on the next 0 sample.
- Stream starting mid-period (5,6,7,6,5,4,4,3,2,1,0,1): no err while in HUNT; locked rises the cycle after the 0; expected next value is 1, which matches.
- en toggled 1/0 alternately with an ideal stream presented only on en=1: no err; phase holds on en=0 cycles; exp_cnt stable while en=0.
- ERR_W=2 with 5 mismatches spaced by matches: err_count saturates at 3; clr_err asserted together with a mismatch gives err_count=1; assert rst mid-SLIP → all outputs 0 immediately, asynchronously.
